// File: rtl/lane_reorder_lock_rx_if.sv
// ----------------------------------------------------------------------------
// lane_reorder_lock_rx_if
//   Bundles the receive-side signals of the lane reorder block.
//   master : upstream AM-lock side (drives valid_i/marker_v_i/lane_i/block_i,
//            observes the reordered outputs)
//   slave  : the lane reorder block itself
//   Signals:
//     valid_i     block_i valid this cycle
//     marker_v_i  per physical lane, alignment marker seen this cycle
//     lane_i      per physical lane i, one-hot logical ID at [i*LANE_N +: LANE_N]
//     block_i     unordered blocks, physical lane i at [i*BLOCK_W +: BLOCK_W]
//     valid_o     block_o valid
//     block_o     reordered blocks, logical lane j at [j*BLOCK_W +: BLOCK_W]
//     lock_o      lane map locked
//     err_o       one-cycle pulse: marker period failed the check
//     err_cnt_o   saturating err_o pulse count (only with LANE_REORDER_ERR_CNT_EN)
// ----------------------------------------------------------------------------
interface lane_reorder_lock_rx_if #(
    parameter int LANE_N  = 4,
    parameter int BLOCK_W = 66
`ifdef LANE_REORDER_ERR_CNT_EN
   ,parameter int ERR_CNT_W = 8
`endif
);
    logic                        valid_i;
    logic [LANE_N-1:0]           marker_v_i;
    logic [LANE_N*LANE_N-1:0]    lane_i;
    logic [LANE_N*BLOCK_W-1:0]   block_i;
    logic                        valid_o;
    logic [LANE_N*BLOCK_W-1:0]   block_o;
    logic                        lock_o;
    logic                        err_o;
`ifdef LANE_REORDER_ERR_CNT_EN
    logic [ERR_CNT_W-1:0]        err_cnt_o;

    modport master (
        output valid_i, marker_v_i, lane_i, block_i,
        input  valid_o, block_o, lock_o, err_o, err_cnt_o
    );
    modport slave (
        input  valid_i, marker_v_i, lane_i, block_i,
        output valid_o, block_o, lock_o, err_o, err_cnt_o
    );
`else
    modport master (
        output valid_i, marker_v_i, lane_i, block_i,
        input  valid_o, block_o, lock_o, err_o
    );
    modport slave (
        input  valid_i, marker_v_i, lane_i, block_i,
        output valid_o, block_o, lock_o, err_o
    );
`endif
endinterface

// File: rtl/lane_reorder_lock_rx.sv
// ----------------------------------------------------------------------------
// lane_reorder_lock_rx
//   Sequential lane reorder for the multi-lane PCS receive path. Learns the
//   physical-to-logical lane map from alignment-marker lane IDs, locks it,
//   re-verifies it on every marker period and unlocks after MISMATCH_MAX
//   consecutive bad marker periods. Output is registered (1-cycle latency)
//   and logically ordered; marker cycles are dropped from the data stream.
//
//   Ports:
//     clk    clock
//     reset  asynchronous, active-high reset
//     bus    lane_reorder_lock_rx_if.slave (valid_i, marker_v_i, lane_i,
//            block_i in; valid_o, block_o, lock_o, err_o out)
//
//   Optional feature macro: LANE_REORDER_ERR_CNT_EN
//     Adds err_cnt_o (ERR_CNT_W bits): saturating count of err_o pulses
//     since reset, not cleared by unlock.
// ----------------------------------------------------------------------------
module lane_reorder_lock_rx #(
    parameter int LANE_N       = 4,
    parameter int BLOCK_W      = 66,
    parameter int MISMATCH_MAX = 3,
    parameter int ERR_CNT_W    = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    lane_reorder_lock_rx_if.slave  bus
);

    localparam int CNT_W = $clog2(MISMATCH_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MISMATCH_MAX - 1);

    localparam logic [0:0] ST_UNLOCKED = 1'b0;
    localparam logic [0:0] ST_LOCKED   = 1'b1;

    generate
        if (MISMATCH_MAX < 1 || ERR_CNT_W < 1) begin : g_bad_param
            $error("lane_reorder_lock_rx: MISMATCH_MAX and ERR_CNT_W must be >= 1");
        end
    endgenerate

    logic [0:0]                  state_q;
    logic [LANE_N*LANE_N-1:0]    map_q;
    logic [CNT_W-1:0]            mis_cnt_q;

    logic                        marker_cyc;
    logic                        full_cyc;
    logic                        map_ok;
    logic [LANE_N-1:0]           lane_union;
    logic [LANE_N*BLOCK_W-1:0]   reorder;
    logic                        err_set;

    assign marker_cyc = bus.valid_i & (|bus.marker_v_i);
    assign full_cyc   = bus.valid_i & (&bus.marker_v_i);

    // The incoming IDs form a permutation when every slice is one-hot and
    // together they cover every logical lane.
    // NOTE: every signal driven here gets a default first so no latch is inferred.
    always_comb begin
        map_ok     = 1'b1;
        lane_union = '0;
        for (int i = 0; i < LANE_N; i++) begin
            if (!$onehot(bus.lane_i[i*LANE_N +: LANE_N])) begin
                map_ok = 1'b0;
            end
            lane_union = lane_union | bus.lane_i[i*LANE_N +: LANE_N];
        end
        if (lane_union != {LANE_N{1'b1}}) begin
            map_ok = 1'b0;
        end
    end

    // Logical lane j takes physical lane i where map[i][j] is set. The stored
    // map is always a permutation while locked, so at most one i matches.
    always_comb begin
        reorder = '0;
        for (int j = 0; j < LANE_N; j++) begin
            for (int i = 0; i < LANE_N; i++) begin
                if (map_q[i*LANE_N + j]) begin
                    reorder[j*BLOCK_W +: BLOCK_W] = bus.block_i[i*BLOCK_W +: BLOCK_W];
                end
            end
        end
    end

    // A locked marker period fails unless all lanes carry markers and the IDs
    // repeat the stored map exactly.
    assign err_set = (state_q == ST_LOCKED) && marker_cyc &&
                     !(full_cyc && (bus.lane_i == map_q));

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_UNLOCKED;
            // NOTE: the map is a small register, not a RAM, so it is reset
            // along with the rest of the state.
            map_q       <= '0;
            mis_cnt_q   <= '0;
            bus.valid_o <= 1'b0;
            bus.block_o <= '0;
            bus.lock_o  <= 1'b0;
            bus.err_o   <= 1'b0;
        end else begin
            bus.err_o   <= 1'b0;
            bus.valid_o <= bus.valid_i && (state_q == ST_LOCKED) && !marker_cyc;

            if (bus.valid_i && (state_q == ST_LOCKED) && !marker_cyc) begin
                bus.block_o <= reorder;
            end

            if (bus.valid_i) begin
                case (state_q)
                    ST_UNLOCKED: begin
                        if (full_cyc && map_ok) begin
                            map_q      <= bus.lane_i;
                            mis_cnt_q  <= '0;
                            state_q    <= ST_LOCKED;
                            bus.lock_o <= 1'b1;
                        end
                    end
                    default: begin
                        if (err_set) begin
                            bus.err_o <= 1'b1;
                            if (mis_cnt_q == CNT_LAST) begin
                                state_q    <= ST_UNLOCKED;
                                map_q      <= '0;
                                mis_cnt_q  <= '0;
                                bus.lock_o <= 1'b0;
                            end else begin
                                mis_cnt_q <= mis_cnt_q + 1'b1;
                            end
                        end else if (marker_cyc) begin
                            mis_cnt_q <= '0;
                        end
                    end
                endcase
            end
        end
    end

`ifdef LANE_REORDER_ERR_CNT_EN
    // Counts in the same update that raises err_o, so the count and the pulse
    // become visible together; sticks at all-ones.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.err_cnt_o <= '0;
        end else if (bus.valid_i && err_set && (bus.err_cnt_o != {ERR_CNT_W{1'b1}})) begin
            bus.err_cnt_o <= bus.err_cnt_o + 1'b1;
        end
    end
`else
`endif

endmodule

// File: tb/tb_lane_reorder_lock_rx.sv
module tb_lane_reorder_lock_rx;

    localparam int LANE_N  = 4;
    localparam int BLOCK_W = 66;
    localparam int DW      = LANE_N * BLOCK_W;

    // phys0..3 -> logical 2,0,3,1 and the same map with phys0/phys1 swapped
    localparam logic [15:0] MAP_GOOD = 16'h2814;
    localparam logic [15:0] MAP_SWAP = 16'h2841;
    localparam logic [15:0] MAP_DUP  = 16'h2811;

    localparam logic [65:0] A = 66'h3_0123_4567_89AB_CDE1;
    localparam logic [65:0] B = 66'h2_1111_2222_3333_4442;
    localparam logic [65:0] C = 66'h1_5555_6666_7777_8883;
    localparam logic [65:0] D = 66'h0_9999_AAAA_BBBB_CCC4;
    localparam logic [65:0] E = 66'h3_DEAD_BEEF_0000_0005;
    localparam logic [65:0] F = 66'h2_FEED_FACE_0000_0006;
    localparam logic [65:0] G = 66'h1_CAFE_F00D_0000_0007;
    localparam logic [65:0] H = 66'h0_0BAD_C0DE_0000_0008;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

`ifdef LANE_REORDER_ERR_CNT_EN
    lane_reorder_lock_rx_if #(.LANE_N(LANE_N), .BLOCK_W(BLOCK_W), .ERR_CNT_W(8)) bus ();
`else
    lane_reorder_lock_rx_if #(.LANE_N(LANE_N), .BLOCK_W(BLOCK_W)) bus ();
`endif

    lane_reorder_lock_rx #(
        .LANE_N(LANE_N), .BLOCK_W(BLOCK_W), .MISMATCH_MAX(3), .ERR_CNT_W(8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    typedef struct {
        logic          v;
        logic [3:0]    mk;
        logic [15:0]   lane;
        logic [DW-1:0] blk;
        logic          ev;
        logic [DW-1:0] eblk;
        logic          elock;
        logic          eerr;
    } vec_t;

    vec_t vecs [13];

    function automatic logic [DW-1:0] pk(input logic [65:0] l0, input logic [65:0] l1,
                                         input logic [65:0] l2, input logic [65:0] l3);
        return {l3, l2, l1, l0};
    endfunction

    task automatic check_bit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic check_blk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic ev, input logic [DW-1:0] eblk,
                             input logic elock, input logic eerr);
        check_bit({tag, " valid_o"}, bus.valid_o, ev);
        check_blk({tag, " block_o"}, bus.block_o, eblk);
        check_bit({tag, " lock_o"},  bus.lock_o,  elock);
        check_bit({tag, " err_o"},   bus.err_o,   eerr);
    endtask

    // Apply one cycle of inputs; outputs are sampled 1 ns after the edge.
    task automatic drive(input logic v, input logic [3:0] mk, input logic [15:0] lane,
                         input logic [DW-1:0] blk);
        bus.valid_i    = v;
        bus.marker_v_i = mk;
        bus.lane_i     = lane;
        bus.block_i    = blk;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [DW-1:0] abcd_o;
        logic [DW-1:0] efgh_o;
        abcd_o = pk(B, D, A, C);
        efgh_o = pk(F, H, E, G);

        //           v     mk     lane      blk            ev    eblk    lock  err
        vecs[0]  = '{1'b0, 4'h0, 16'h0,    '0,            1'b0, '0,     1'b0, 1'b0};
        vecs[1]  = '{1'b1, 4'hF, MAP_DUP,  '0,            1'b0, '0,     1'b0, 1'b0};
        vecs[2]  = '{1'b1, 4'h7, MAP_GOOD, '0,            1'b0, '0,     1'b0, 1'b0};
        vecs[3]  = '{1'b1, 4'h0, MAP_GOOD, pk(A, B, C, D), 1'b0, '0,     1'b0, 1'b0};
        vecs[4]  = '{1'b1, 4'hF, MAP_GOOD, '0,            1'b0, '0,     1'b1, 1'b0};
        vecs[5]  = '{1'b1, 4'h0, MAP_GOOD, pk(A, B, C, D), 1'b1, abcd_o, 1'b1, 1'b0};
        vecs[6]  = '{1'b0, 4'h0, MAP_GOOD, pk(E, F, G, H), 1'b0, abcd_o, 1'b1, 1'b0};
        vecs[7]  = '{1'b1, 4'h0, MAP_GOOD, pk(E, F, G, H), 1'b1, efgh_o, 1'b1, 1'b0};
        vecs[8]  = '{1'b0, 4'hF, MAP_SWAP, pk(A, B, C, D), 1'b0, efgh_o, 1'b1, 1'b0};
        vecs[9]  = '{1'b1, 4'hF, MAP_GOOD, pk(A, B, C, D), 1'b0, efgh_o, 1'b1, 1'b0};
        vecs[10] = '{1'b1, 4'h7, MAP_GOOD, pk(A, B, C, D), 1'b0, efgh_o, 1'b1, 1'b1};
        vecs[11] = '{1'b1, 4'h0, MAP_GOOD, pk(A, B, C, D), 1'b1, abcd_o, 1'b1, 1'b0};
        vecs[12] = '{1'b1, 4'hF, MAP_GOOD, pk(E, F, G, H), 1'b0, abcd_o, 1'b1, 1'b0};

        reset          = 1'b1;
        bus.valid_i    = 1'b0;
        bus.marker_v_i = '0;
        bus.lane_i     = '0;
        bus.block_i    = '0;
        repeat (2) @(posedge clk);
        #1;
        check_out("reset", 1'b0, '0, 1'b0, 1'b0);
`ifdef LANE_REORDER_ERR_CNT_EN
        check_blk("reset err_cnt_o", DW'(bus.err_cnt_o), '0);
`endif
        reset = 1'b0;

        // Lock, stream, markers and partial-marker error, one row per cycle.
        for (int k = 0; k < 13; k++) begin
            drive(vecs[k].v, vecs[k].mk, vecs[k].lane, vecs[k].blk);
            check_out($sformatf("vec%0d", k), vecs[k].ev, vecs[k].eblk, vecs[k].elock, vecs[k].eerr);
        end

        // Three bad marker periods, data in between, unlock on the third.
        drive(1'b1, 4'hF, MAP_SWAP, '0);
        check_out("bad1", 1'b0, abcd_o, 1'b1, 1'b1);
        drive(1'b1, 4'h0, MAP_GOOD, pk(E, F, G, H));
        check_out("bad1 data", 1'b1, efgh_o, 1'b1, 1'b0);
        drive(1'b1, 4'hF, MAP_SWAP, '0);
        check_out("bad2", 1'b0, efgh_o, 1'b1, 1'b1);
        drive(1'b1, 4'hF, MAP_SWAP, '0);
        check_out("bad3 unlock", 1'b0, efgh_o, 1'b0, 1'b1);
        drive(1'b1, 4'h0, MAP_GOOD, pk(A, B, C, D));
        check_out("after unlock", 1'b0, efgh_o, 1'b0, 1'b0);

        // Two bad then a good period clears the count; three more needed to unlock.
        drive(1'b1, 4'hF, MAP_GOOD, '0);
        check_out("relock", 1'b0, efgh_o, 1'b1, 1'b0);
        drive(1'b1, 4'hF, MAP_SWAP, '0);
        check_out("clr bad1", 1'b0, efgh_o, 1'b1, 1'b1);
        drive(1'b1, 4'h3, MAP_GOOD, '0);
        check_out("clr bad2", 1'b0, efgh_o, 1'b1, 1'b1);
        drive(1'b1, 4'hF, MAP_GOOD, '0);
        check_out("clr good", 1'b0, efgh_o, 1'b1, 1'b0);
        drive(1'b1, 4'hF, MAP_DUP, '0);
        check_out("clr bad3", 1'b0, efgh_o, 1'b1, 1'b1);
        drive(1'b1, 4'hF, MAP_SWAP, '0);
        check_out("clr bad4", 1'b0, efgh_o, 1'b1, 1'b1);
        drive(1'b1, 4'hF, MAP_SWAP, '0);
        check_out("clr bad5 unlock", 1'b0, efgh_o, 1'b0, 1'b1);

        // Reset mid-stream clears outputs without waiting for an edge.
        drive(1'b1, 4'hF, MAP_GOOD, '0);
        drive(1'b1, 4'h0, MAP_GOOD, pk(A, B, C, D));
        check_out("pre reset", 1'b1, abcd_o, 1'b1, 1'b0);
        reset = 1'b1;
        #1;
        check_out("async reset", 1'b0, '0, 1'b0, 1'b0);
        drive(1'b1, 4'h0, MAP_GOOD, pk(E, F, G, H));
        check_out("held reset", 1'b0, '0, 1'b0, 1'b0);
        reset = 1'b0;
        drive(1'b1, 4'h0, MAP_GOOD, pk(E, F, G, H));
        check_out("post reset", 1'b0, '0, 1'b0, 1'b0);

`ifdef LANE_REORDER_ERR_CNT_EN
        check_blk("err_cnt after reset", DW'(bus.err_cnt_o), '0);
        // 87 lock/unlock rounds of 3 errors = 261 pulses, saturating at 255.
        for (int k = 0; k < 87; k++) begin
            drive(1'b1, 4'hF, MAP_GOOD, '0);
            repeat (3) drive(1'b1, 4'hF, MAP_SWAP, '0);
        end
        check_blk("err_cnt saturate", DW'(bus.err_cnt_o), DW'(255));
        check_bit("err_cnt final lock", bus.lock_o, 1'b0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
